// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, and fetches from a
// variable-latency memory with at most one request outstanding.
module if_stage_fetch_unit #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [DATA_W-1:0] if_id_instr,
   output logic              if_id_valid
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      STALL = 2'd1,
      DROP  = 2'd2
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
      logic              valid;
   } ifid_t;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
   logic [ADDR_W-1:0] redirect_q, redirect_d;
   ifid_t             buf_q, buf_d;
   ifid_t             ifid_q, ifid_d;

   logic              ack_acc;
   logic [ADDR_W-1:0] fetch_inc;
   ifid_t             bubble;
   ifid_t             fetched;

   // An ack only counts while a request is actually on the bus.
   assign ack_acc   = imem_ack && (state_q != STALL);
   assign fetch_inc = fetch_addr_q + PC_STEP;
   assign bubble    = '{pc: ifid_q.pc, instr: NOP_INSTR, valid: 1'b0};
   assign fetched   = '{pc: fetch_inc, instr: imem_rdata, valid: 1'b1};

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      redirect_d   = redirect_q;
      buf_d        = buf_q;
      ifid_d       = ifid_q;
      unique case (state_q)
         FETCH: begin
            if (branch_taken) begin
               ifid_d = bubble;
               if (ack_acc) begin
                  fetch_addr_d = branch_addr;
               end else begin
                  // Request is still in flight; remember the target until it returns.
                  redirect_d = branch_addr;
                  state_d    = DROP;
               end
            end else if (ack_acc) begin
               fetch_addr_d = fetch_inc;
               if (freeze) begin
                  buf_d   = fetched;
                  state_d = STALL;
               end else begin
                  ifid_d = fetched;
               end
            end else if (!freeze) begin
               ifid_d = bubble;
            end
         end
         STALL: begin
            if (branch_taken) begin
               ifid_d       = bubble;
               buf_d.valid  = 1'b0;
               fetch_addr_d = branch_addr;
               state_d      = FETCH;
            end else if (!freeze) begin
               ifid_d      = buf_q;
               buf_d.valid = 1'b0;
               state_d     = FETCH;
            end
         end
         DROP: begin
            if (branch_taken) begin
               redirect_d = branch_addr;
            end
            if (ack_acc) begin
               fetch_addr_d = branch_taken ? branch_addr : redirect_q;
               state_d      = FETCH;
            end
            if (branch_taken || !freeze) begin
               ifid_d = bubble;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FETCH;
         fetch_addr_q <= RESET_PC;
         redirect_q   <= RESET_PC;
         buf_q        <= '0;
         ifid_q       <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         redirect_q   <= redirect_d;
         buf_q        <= buf_d;
         ifid_q       <= ifid_d;
      end
   end

   assign imem_req    = rst_n && (state_q != STALL);
   assign imem_addr   = fetch_addr_q;
   assign if_id_pc    = ifid_q.pc;
   assign if_id_instr = ifid_q.instr;
   assign if_id_valid = ifid_q.valid;

   a_buf_only_in_stall : assert property (
      @(posedge clk) disable iff (!rst_n) buf_q.valid == (state_q == STALL));

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// Bench for if_stage_fetch_unit: directed scenarios pinned with literal values, then
// random freeze/branch/latency traffic checked every cycle against a behavioural model.
module tb_if_stage_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        freeze = 1'b0, branch_taken = 1'b0, imem_ack = 1'b0;
   logic [31:0] branch_addr = '0, imem_rdata = '0;
   logic        imem_req, if_id_valid;
   logic [31:0] imem_addr, if_id_pc, if_id_instr;

   always #5 clk = ~clk;

   if_stage_fetch_unit #(
      .ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC), .NOP_INSTR(NOP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_pc(if_id_pc),
      .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
   );

   int n_chk = 0, n_fail = 0;

   // Model: "in reset", "returned word parked", "pending fetch is stale".
   bit          m_rst = 1'b1, m_bv = 1'b0, m_stale = 1'b0, m_valid = 1'b0;
   logic [31:0] m_fetch = RST_PC, m_redir = RST_PC, m_bpc = '0, m_binstr = '0;
   logic [31:0] m_pc = '0, m_instr = NOP;
   int          mem_wait = -1;
   bit          rnd_mode = 1'b0;

   function automatic bit m_req();
      return !m_rst && !m_bv;
   endfunction

   function automatic logic [31:0] mem_func(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_bubble();
      m_valid = 1'b0;
      m_instr = NOP;
   endtask

   task automatic model_reset();
      m_rst = 1'b1; m_bv = 1'b0; m_stale = 1'b0;
      m_fetch = RST_PC; m_redir = RST_PC;
      m_pc = '0; m_instr = NOP; m_valid = 1'b0;
      mem_wait = -1;
   endtask

   // What one clock edge does, given this cycle's inputs.
   task automatic model_step(input bit fz, input bit br, input logic [31:0] ba,
                             input bit ack, input logic [31:0] rd);
      bit acc;
      acc = ack && m_req();
      if (m_bv) begin
         if (br) begin
            m_bv = 1'b0; m_fetch = ba; m_bubble();
         end else if (!fz) begin
            m_pc = m_bpc; m_instr = m_binstr; m_valid = 1'b1; m_bv = 1'b0;
         end
      end else if (m_stale) begin
         if (br) m_redir = ba;
         if (acc) begin m_fetch = m_redir; m_stale = 1'b0; end
         if (br || !fz) m_bubble();
      end else if (br) begin
         m_bubble();
         if (acc) m_fetch = ba;
         else begin m_redir = ba; m_stale = 1'b1; end
      end else if (acc) begin
         if (fz) begin m_bv = 1'b1; m_bpc = m_fetch + 32'd4; m_binstr = rd; end
         else begin m_pc = m_fetch + 32'd4; m_instr = rd; m_valid = 1'b1; end
         m_fetch = m_fetch + 32'd4;
      end else if (!fz) begin
         m_bubble();
      end
   endtask

   task automatic compare_all();
      chk("imem_req", 32'(imem_req), 32'(m_req()));
      chk("imem_addr", imem_addr, m_fetch);
      chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
      chk("if_id_pc", if_id_pc, m_pc);
      chk("if_id_instr", if_id_instr, m_instr);
      if (rnd_mode && if_id_valid === 1'b1)
         chk("stream_order", if_id_instr, mem_func(if_id_pc - 32'd4));
   endtask

   // Called at a falling edge: drive inputs, advance model, sample at next falling edge.
   task automatic step(input bit fz, input bit br, input logic [31:0] ba,
                       input bit ack, input logic [31:0] rd);
      freeze = fz; branch_taken = br; branch_addr = ba; imem_ack = ack; imem_rdata = rd;
      model_step(fz, br, ba, ack, rd);
      @(negedge clk);
      compare_all();
   endtask

   task automatic async_reset(input bit pin);
      #2;
      rst_n = 1'b0;
      freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
      model_reset();
      #1;
      if (pin) begin
         chk("rst_req", 32'(imem_req), 32'h0);
         chk("rst_pc", if_id_pc, 32'h0);
         chk("rst_instr", if_id_instr, NOP);
         chk("rst_valid", 32'(if_id_valid), 32'h0);
      end
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      m_rst = 1'b0;
      #1;
      compare_all();
      if (pin) chk("post_rst_addr", imem_addr, RST_PC);
   endtask

   initial begin
      @(negedge clk);
      compare_all();
      chk("reset_req", 32'(imem_req), 32'h0);
      chk("reset_instr", if_id_instr, NOP);
      rst_n = 1'b1;
      m_rst = 1'b0;

      // Zero-latency stream
      step(0, 0, 0, 1, 32'hE000_0001);
      chk("zl_pc0", if_id_pc, 32'h4);
      chk("zl_instr0", if_id_instr, 32'hE000_0001);
      chk("zl_addr1", imem_addr, 32'h4);
      step(0, 0, 0, 1, 32'hE000_0002);
      step(0, 0, 0, 1, 32'hE000_0003);
      chk("zl_pc2", if_id_pc, 32'hC);
      chk("zl_valid", 32'(if_id_valid), 32'h1);

      // Latency 3: two bubbles, address held
      step(0, 0, 0, 0, 0);
      chk("lat_bubble_v", 32'(if_id_valid), 32'h0);
      chk("lat_bubble_i", if_id_instr, NOP);
      chk("lat_addr_hold", imem_addr, 32'hC);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'hE000_0004);
      chk("lat_pc", if_id_pc, 32'h10);

      // Freeze over a return at 0x10
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'hE000_0005);
      chk("frz_req", 32'(imem_req), 32'h0);
      chk("frz_hold_pc", if_id_pc, 32'h10);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("frz_rel_pc", if_id_pc, 32'h14);
      chk("frz_rel_instr", if_id_instr, 32'hE000_0005);
      chk("frz_next_addr", imem_addr, 32'h14);

      // Branch while a fetch at 0x20 is pending
      step(0, 0, 0, 1, 32'hE000_0006);
      step(0, 0, 0, 1, 32'hE000_0007);
      step(0, 0, 0, 1, 32'hE000_0008);
      chk("br_pend_addr", imem_addr, 32'h20);
      step(0, 1, 32'h100, 0, 0);
      chk("br_bubble", 32'(if_id_valid), 32'h0);
      chk("br_stale_addr", imem_addr, 32'h20);
      step(0, 0, 0, 1, 32'hDEAD_BEEF);
      chk("br_discard", if_id_instr, NOP);
      chk("br_target", imem_addr, 32'h100);
      step(0, 0, 0, 1, 32'hE000_0100);
      chk("br_first_pc", if_id_pc, 32'h104);
      chk("br_first_instr", if_id_instr, 32'hE000_0100);

      // Branch + freeze together while stalled
      step(1, 0, 0, 1, 32'hE000_0101);
      step(1, 1, 32'h40, 0, 0);
      chk("bf_valid", 32'(if_id_valid), 32'h0);
      chk("bf_req", 32'(imem_req), 32'h1);
      chk("bf_addr", imem_addr, 32'h40);

      // Async reset with a request outstanding
      step(0, 0, 0, 0, 0);
      async_reset(1'b1);

      // Random traffic
      rnd_mode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         bit fz, br, ack;
         logic [31:0] ba, rd;
         fz = ($urandom_range(0, 3) == 0);
         br = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 7))
            0:       ba = 32'hFFFF_FFF8;
            1:       ba = 32'hFFFF_FFFC;
            default: ba = $urandom & 32'hFFFF_FFFC;
         endcase
         if (m_req()) begin
            if (mem_wait < 0) mem_wait = int'($urandom_range(0, 3));
            ack = (mem_wait == 0);
            mem_wait = ack ? -1 : mem_wait - 1;
            rd = mem_func(m_fetch);
         end else begin
            ack = ($urandom_range(0, 3) == 0);
            rd = $urandom;
         end
         step(fz, br, ba, ack, rd);
         if (c == 1500) async_reset(1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/if_stage_fetch_unit.md
Name: if_stage_fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the hazard detection unit.
- Owns the PC and the IF/ID pipeline register, and talks to a variable-latency instruction memory over a req/ack handshake.
- Consumes the hazard unit's Hazard signal as freeze, and the EXE-stage branch resolution as redirect/flush.
- A one-entry skid buffer holds an instruction that returns while the pipeline is frozen.

Parameters:
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction width
RESET_PC, 0, first fetch address after reset
NOP_INSTR, 0, value driven on if_id_instr for a bubble

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
freeze  in  1  Hazard from the hazard detection unit; hold IF/ID
branch_taken  in  1  redirect request from EXE; flush IF/ID
branch_addr  in  ADDR_W  redirect target
imem_req  out  1  fetch request (level)
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  DATA_W  fetched instruction
if_id_pc  out  ADDR_W  fetched address + 4
if_id_instr  out  DATA_W  instruction to the ID stage
if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=FETCH, fetch_addr=RESET_PC, redirect_addr=RESET_PC, buf_valid=0.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - imem_req is forced 0 while rst_n=0.
- Memory protocol:
  - At most one request is outstanding.
  - imem_req=1 in FETCH and DROP, 0 in STALL.
  - imem_addr=fetch_addr, which is held constant until ack.
  - ack may arrive in the same cycle the request appears, or any later cycle.
  - ack while imem_req=0 is ignored.
- Priority each cycle: branch_taken > freeze > advance.
- FETCH:
  - ack & branch_taken: discard data; fetch_addr<=branch_addr; stay FETCH.
  - ack & freeze: buf<=imem_rdata with pc fetch_addr+4, buf_valid<=1; fetch_addr<=fetch_addr+4; ->STALL.
  - ack & advance: IF/ID<={fetch_addr+4, imem_rdata, 1}; fetch_addr<=fetch_addr+4; stay FETCH.
  - no ack & branch_taken: redirect_addr<=branch_addr; ->DROP. fetch_addr is unchanged, so the request stays pending.
  - no ack & advance: IF/ID loads a bubble (valid=0, instr=NOP_INSTR, pc unchanged).
- STALL (buf_valid=1, no request):
  - branch_taken: buf_valid<=0; fetch_addr<=branch_addr; ->FETCH.
  - freeze: hold everything.
  - otherwise: IF/ID<=buf; buf_valid<=0; ->FETCH. The next request issues in the following cycle at fetch_addr.
- DROP (stale request outstanding):
  - branch_taken again: redirect_addr<=branch_addr.
  - ack: discard data; fetch_addr<=redirect_addr (the updated value if branch_taken is also asserted this cycle); ->FETCH.
  - IF/ID loads a bubble unless freeze is asserted.
- IF/ID register rules:
  - branch_taken in any state forces a bubble into IF/ID, overriding freeze.
  - freeze without branch holds IF/ID unchanged.
- Arithmetic: PC increment is +4, modulo 2^ADDR_W. The all-ones wrap is legal and silent.
- Invariants:
  - buf_valid=1 only in STALL.
  - Exactly one of (IF/ID load, buffer load, discard) happens per accepted ack.
- Reset mid-request:
  - The outstanding request is abandoned.
  - The memory must not ack after reset; the bench guarantees this.

Test Plan:
- Zero-latency stream: ack every cycle with rdata=0xE0000001,0xE0000002,... -> imem_addr 0,4,8; if_id_pc 4,8,12 with matching instrs one cycle later; valid=1 continuous.
- Latency 3: ack 3 cycles after each req -> two bubbles (valid=0, instr=NOP) between instructions; imem_addr held stable during the wait.
- Freeze over return: freeze=1 for 4 cycles, ack at addr 0x10 during freeze:
  - state STALL, imem_req=0, IF/ID unchanged.
  - On release, if_id_pc=0x14 with buffered instr.
  - Next req at 0x14.
- Branch while pending: req at 0x20, branch_taken with branch_addr=0x100 before ack:
  - IF/ID bubble; DROP state.
  - ack with 0xDEADBEEF is discarded.
  - Next imem_addr=0x100; first valid if_id_pc=0x104.
- Branch and freeze together in STALL: branch_taken=1, freeze=1, branch_addr=0x40 -> buffer dropped, if_id_valid=0, next req 0x40.
- Async reset mid-stream: rst_n low between clock edges -> outputs zero/NOP immediately, imem_req=0; after release first req at RESET_PC.
